// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the MEM-stage access unit
//
// Purpose : size encodings, FSM state enum and the latched request record
//           used by mem_access_unit and load_extend.
// Contents: MEM_BYTE/MEM_HALF/MEM_WORD, mau_state_t, mem_req_t,
//           mem_req_illegal() helper.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } mau_state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // A request is illegal when it asks for both directions, uses the
  // reserved size code, or is misaligned for its access width.
  function automatic logic mem_req_illegal(
    input logic       read,
    input logic       write,
    input logic [1:0] size,
    input logic [1:0] offset
  );
    logic bad;
    bad = 1'b0;
    if (read && write)                          bad = 1'b1;
    if (size == 2'b11)                          bad = 1'b1;
    if ((size == MEM_HALF) && offset[0])        bad = 1'b1;
    if ((size == MEM_WORD) && (offset != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - load data lane select and sign/zero extension
//
// Purpose : pick the addressed byte/half out of a RAM word and extend it
//           to 32 bits. Purely combinational.
// Ports   : word   in  32  raw RAM word
//           offset in  2   byte offset within the word
//           size   in  2   MEM_BYTE / MEM_HALF / MEM_WORD
//           sign   in  1   1 = sign-extend, 0 = zero-extend
//           value  out 32  extended result
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    value = word;
    case (size)
      MEM_BYTE: value = {{24{sign & byte_sel[7]}}, byte_sel};
      MEM_HALF: value = {{16{sign & half_sel[15]}}, half_sel};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving a word-wide synchronous RAM
//
// Purpose : accepts one load/store per handshake, drives the data RAM with
//           byte enables, returns aligned/extended load data and flags
//           illegal requests. One request outstanding at a time.
// Ports   : clk, reset (sync, active-high)
//           req_valid/req_ready, mem_read, mem_write, mem_size, mem_sign,
//           addr, wdata                          - request side
//           resp_valid/resp_ready, rdata, resp_err - response side
//           ram_en, ram_we, ram_addr, ram_wdata, ram_rdata - RAM side
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // Three bits cover the full 1..7 latency range.
  localparam int         CNT_W    = 3;
  localparam logic [2:0] CNT_INIT = CNT_W'(RAM_LATENCY - 1);

  mau_state_t  state;
  mau_state_t  state_next;
  mem_req_t    req;
  mem_req_t    req_in;
  logic [2:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        illegal;
  logic        noop;
  logic        ram_en_raw;
  logic [3:0]  ram_we_raw;
  logic [3:0]  store_mask;
  logic [31:0] load_value;
  logic        unused_addr_bits;

  assign req_in = '{
    read:  mem_read,
    write: mem_write,
    size:  mem_size,
    sign:  mem_sign,
    addr:  addr,
    wdata: wdata
  };

  assign illegal = mem_req_illegal(mem_read, mem_write, mem_size, addr[1:0]);
  assign noop    = !mem_read && !mem_write;

  // Address bits above the RAM word range are latched but never decoded.
  assign unused_addr_bits = ^req.addr[31:ADDR_W+2];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_en_raw = 1'b0;
    ram_we_raw = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Illegal and no-op requests skip the RAM entirely.
          state_next = (illegal || noop) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        ram_en_raw = 1'b1;
        if (req.write) begin
          ram_we_raw = store_mask;
          state_next = RESP;
        end else if (req.read) begin
          state_next = WAIT;
        end else begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Store lane enables and data replication
  // ---------------------------------------------------------------------
  always_comb begin
    store_mask = 4'b1111;
    case (req.size)
      MEM_BYTE: store_mask = 4'b0001 << req.addr[1:0];
      MEM_HALF: store_mask = 4'b0011 << {req.addr[1], 1'b0};
      default:  store_mask = 4'b1111;
    endcase
  end

  always_comb begin
    ram_wdata = req.wdata;
    case (req.size)
      MEM_BYTE: ram_wdata = {4{req.wdata[7:0]}};
      MEM_HALF: ram_wdata = {2{req.wdata[15:0]}};
      default:  ram_wdata = req.wdata;
    endcase
  end

  // Strobes are gated by reset directly so a write caught mid-ACCESS
  // never reaches the RAM.
  assign ram_en   = ram_en_raw & ~reset;
  assign ram_we   = reset ? 4'b0000 : ram_we_raw;
  assign ram_addr = req.addr[ADDR_W+1:2];

  // ---------------------------------------------------------------------
  // Load data path
  // ---------------------------------------------------------------------
  load_extend u_load_extend (
    .word   (ram_rdata),
    .offset (req.addr[1:0]),
    .size   (req.size),
    .sign   (req.sign),
    .value  (load_value)
  );

  // ---------------------------------------------------------------------
  // Request latch, latency counter, response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      req     <= '0;
      cnt     <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req     <= req_in;
            rdata_q <= 32'd0;
            err_q   <= illegal;
          end
        end
        ACCESS: begin
          cnt <= CNT_INIT;
        end
        WAIT: begin
          // cnt reaching zero marks the cycle ram_rdata is valid.
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            rdata_q <= load_value;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_err_a, ram_en_a;
  logic [31:0] rdata_a, ram_wdata_a, ram_rdata_a;
  logic [3:0]  ram_we_a;
  logic [9:0]  ram_addr_a;

  logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b, ram_en_b;
  logic [31:0] rdata_b, ram_wdata_b, ram_rdata_b;
  logic [3:0]  ram_we_b;
  logic [9:0]  ram_addr_b;

  mem_access_unit #(.RAM_LATENCY(1), .ADDR_W(10)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_sign(mem_sign),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .rdata(rdata_a), .resp_err(resp_err_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
  );

  mem_access_unit #(.RAM_LATENCY(3), .ADDR_W(10)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_sign(mem_sign),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .rdata(rdata_b), .resp_err(resp_err_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
  );

  // RAM models: byte-enabled writes, read data valid RAM_LATENCY cycles after ram_en.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a != 4'b0000) mem_a[ram_addr_a] <= merge(mem_a[ram_addr_a], ram_wdata_a, ram_we_a);
      else pipe_a <= mem_a[ram_addr_a];
    end
  end
  assign ram_rdata_a = pipe_a;

  always @(posedge clk) begin
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (ram_en_b) begin
      if (ram_we_b != 4'b0000) mem_b[ram_addr_b] <= merge(mem_b[ram_addr_b], ram_wdata_b, ram_we_b);
      else pipe_b[0] <= mem_b[ram_addr_b];
    end
  end
  assign ram_rdata_b = pipe_b[2];

  int checks   = 0;
  int failures = 0;

  int          lat;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        saw_en;
  logic [3:0]  got_we;
  logic [31:0] got_ram_addr;
  logic [31:0] got_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle (cycle 0), then scrambles the
  // request inputs so late sampling would be visible. Returns in cycle 1.
  task automatic issue(input bit sel_b, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_sign = sg; addr = a; wdata = d;
    if (sel_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    mem_read = ~rd; mem_write = ~wr; mem_size = ~sz; mem_sign = ~sg; addr = ~a; wdata = ~d;
  endtask

  task automatic wait_resp(input bit sel_b);
    lat = 1; saw_en = 1'b0; got_we = 4'b0000; got_ram_addr = 32'd0; got_wdata = 32'd0;
    while (!(sel_b ? resp_valid_b : resp_valid_a) && lat < 40) begin
      if (sel_b ? ram_en_b : ram_en_a) begin
        saw_en       = 1'b1;
        got_we       = sel_b ? ram_we_b : ram_we_a;
        got_ram_addr = 32'(sel_b ? ram_addr_b : ram_addr_a);
        got_wdata    = sel_b ? ram_wdata_b : ram_wdata_a;
      end
      @(negedge clk);
      lat++;
    end
    got_rdata = sel_b ? rdata_b : rdata_a;
    got_err   = sel_b ? resp_err_b : resp_err_a;
  endtask

  task automatic release_resp(input bit sel_b);
    if (sel_b) resp_ready_b = 1'b1; else resp_ready_a = 1'b1;
    @(negedge clk);
    resp_ready_a = 1'b0; resp_ready_b = 1'b0;
  endtask

  task automatic txn(input bit sel_b, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] d);
    issue(sel_b, rd, wr, sz, sg, a, d);
    wait_resp(sel_b);
    release_resp(sel_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic rd; logic wr; logic [1:0] sz; logic [31:0] a; string tag; } bad_t;
  bad_t bad_tbl [4];

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_sign = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    req_valid_a = 1'b0; req_valid_b = 1'b0; resp_ready_a = 1'b0; resp_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", 32'(req_ready_a), 32'd1);
    check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_resp_err", 32'(resp_err_a), 32'd0);
    check("rst_ram_en", 32'(ram_en_a), 32'd0);
    check("rst_ram_we", 32'(ram_we_a), 32'd0);

    // Word store then word load, latency 1
    txn(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_we", 32'(got_we), 32'hF);
    check("sw_ram_addr", got_ram_addr, 32'd4);
    check("sw_wdata", got_wdata, 32'hDEADBEEF);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_err", 32'(got_err), 32'd0);
    check("sw_rdata", got_rdata, 32'd0);
    check("sw_idle", 32'(req_ready_a), 32'd1);

    txn(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rdata", got_rdata, 32'hDEADBEEF);
    check("lw_latency_l1", 32'(lat), 32'd3);
    check("lw_err", 32'(got_err), 32'd0);
    check("lw_we", 32'(got_we), 32'd0);
    check("lw_idle_rdata", rdata_a, 32'd0);

    // Same pair on the latency-3 instance
    txn(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    txn(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rdata_l3", got_rdata, 32'hDEADBEEF);
    check("lw_latency_l3", 32'(lat), 32'd5);

    // Byte and half loads from the word just written
    txn(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_13_signed", got_rdata, 32'hFFFFFFDE);
    txn(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lbu_13", got_rdata, 32'h000000DE);
    txn(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lb_11_signed", got_rdata, 32'hFFFFFFBE);
    txn(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lhu_10", got_rdata, 32'h0000BEEF);
    txn(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("lh_10_signed", got_rdata, 32'hFFFFBEEF);

    // Half store to upper half, signed half load back
    txn(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234);
    check("sh_we", 32'(got_we), 32'hC);
    check("sh_wdata", got_wdata, 32'h12341234);
    check("sh_ram_addr", got_ram_addr, 32'd8);
    txn(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    check("lh_22_signed", got_rdata, 32'h00001234);

    // Byte store into lane 1 of the word at 0x10
    txn(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
    check("sb_we", 32'(got_we), 32'h2);
    check("sb_wdata", got_wdata, 32'hA5A5A5A5);
    txn(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_after_sb", got_rdata, 32'hDEADA5EF);

    // Illegal requests
    bad_tbl[0] = '{rd: 1'b1, wr: 1'b0, sz: 2'b10, a: 32'h02, tag: "ill_lw_02"};
    bad_tbl[1] = '{rd: 1'b0, wr: 1'b1, sz: 2'b01, a: 32'h05, tag: "ill_sh_05"};
    bad_tbl[2] = '{rd: 1'b1, wr: 1'b0, sz: 2'b11, a: 32'h00, tag: "ill_size11"};
    bad_tbl[3] = '{rd: 1'b1, wr: 1'b1, sz: 2'b10, a: 32'h10, tag: "ill_rdwr"};
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, bad_tbl[i].rd, bad_tbl[i].wr, bad_tbl[i].sz, 1'b1, bad_tbl[i].a, 32'hFFFFFFFF);
      check({bad_tbl[i].tag, "_latency"}, 32'(lat), 32'd1);
      check({bad_tbl[i].tag, "_err"}, 32'(got_err), 32'd1);
      check({bad_tbl[i].tag, "_rdata"}, got_rdata, 32'd0);
      check({bad_tbl[i].tag, "_ram_en"}, 32'(saw_en), 32'd0);
      check({bad_tbl[i].tag, "_err_cleared"}, 32'(resp_err_a), 32'd0);
    end

    // No-op request
    txn(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("noop_latency", 32'(lat), 32'd1);
    check("noop_err", 32'(got_err), 32'd0);
    check("noop_rdata", got_rdata, 32'd0);
    check("noop_ram_en", 32'(saw_en), 32'd0);

    // Backpressure: response held for 4 cycles with a competing request present
    issue(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_resp(1'b0);
    check("bp_latency", 32'(lat), 32'd3);
    mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'b10; addr = 32'h10; wdata = 32'h0;
    req_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_resp_valid", 32'(resp_valid_a), 32'd1);
      check("bp_rdata", rdata_a, 32'hDEADA5EF);
      check("bp_req_ready", 32'(req_ready_a), 32'd0);
      @(negedge clk);
    end
    req_valid_a = 1'b0;
    release_resp(1'b0);
    check("bp_idle_ready", 32'(req_ready_a), 32'd1);
    check("bp_idle_valid", 32'(resp_valid_a), 32'd0);
    check("bp_idle_rdata", rdata_a, 32'd0);
    txn(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("bp_no_accept", got_rdata, 32'hDEADA5EF);

    // Reset during ACCESS of a store
    txn(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    issue(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
    check("rs_access_en", 32'(ram_en_a), 32'd1);
    reset = 1'b1;
    #1;
    check("rs_ram_we", 32'(ram_we_a), 32'd0);
    check("rs_ram_en", 32'(ram_en_a), 32'd0);
    @(negedge clk);
    check("rs_req_ready", 32'(req_ready_a), 32'd1);
    check("rs_resp_valid", 32'(resp_valid_a), 32'd0);
    check("rs_rdata", rdata_a, 32'd0);
    check("rs_resp_err", 32'(resp_err_a), 32'd0);
    reset = 1'b0;
    txn(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("rs_prior_contents", got_rdata, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
